// File: rtl/cnt_pkg.sv
// Shared definitions for the increment arbiter slice.
//   req_state_t : per-requester FSM state encoding
//   idx_w()     : width of a digit index (never below 1 bit)
// Optional build macro used by the slice: INC_ARB_AUTOREPEAT_EN.
package cnt_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    HOLD   = 3'd2,
    REPEAT = 3'd3,
    DONE   = 3'd4
  } req_state_t;

  function automatic int idx_w(input int digits);
    return (digits <= 1) ? 1 : $clog2(digits);
  endfunction

endpackage

// File: rtl/inc_req_timer.sv
// One button requester: press detection plus optional press-and-hold
// auto-repeat timing.
// Build macro: INC_ARB_AUTOREPEAT_EN
//   defined   : FIRST -> HOLD -> REPEAT auto-repeat with a tick counter
//   undefined : FIRST -> DONE, one increment per press, no counter
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_req      : synchronized button level
//   i_tick     : prescaler strobe (arbitration instant)
//   i_grant    : this requester won the current tick
//   o_due      : requester wants an increment (from registered state only)
//   o_state    : current FSM state, for observation
module inc_req_timer
  import cnt_pkg::*;
#(
  parameter int HOLD_TICKS   = 4,
  parameter int REPEAT_TICKS = 2,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req,
  input  logic       i_tick,
  input  logic       i_grant,
  output logic       o_due,
  output req_state_t o_state
);

  req_state_t r_state;

  assign o_state = r_state;

`ifdef INC_ARB_AUTOREPEAT_EN
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_cnt_inc;

  // One extra bit so a saturated counter still compares correctly.
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);

  assign o_due = (r_state == FIRST) ||
                 ((r_state == HOLD)   && (w_cnt_inc >= (CNT_W+1)'(HOLD_TICKS))) ||
                 ((r_state == REPEAT) && (w_cnt_inc >= (CNT_W+1)'(REPEAT_TICKS)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (!i_req) begin
      // Release wins over a same-cycle grant; the grant's pulse still fires.
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE:  r_state <= FIRST;
        FIRST: begin
          if (i_grant) begin
            r_state <= HOLD;
            r_cnt   <= '0;
          end
        end
        HOLD, REPEAT: begin
          if (i_grant) begin
            r_state <= REPEAT;
            r_cnt   <= '0;
          end else if (i_tick && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end
`else
  // Timing parameters and the tick have no meaning without auto-repeat.
  logic w_unused_cfg;
  assign w_unused_cfg = i_tick ^ ((HOLD_TICKS + REPEAT_TICKS + CNT_W) > 0);

  assign o_due = (r_state == FIRST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (!i_req) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    r_state <= FIRST;
        FIRST:   if (i_grant) r_state <= DONE;
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: rtl/inc_arbiter.sv
// Shares one increment path among DIGITS button requesters. On each tick
// the due requesters are searched round-robin from the pointer; the winner
// gets a one-cycle inc_pulse the following cycle.
// Build macro: INC_ARB_AUTOREPEAT_EN (press-and-hold auto-repeat).
// Valid/ready note: there is no back-pressure; tick is the only "valid",
// and a grant is always accepted by the counter receiving inc_pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : synchronized button levels, one per digit
//   tick       : prescaler strobe, arbitration instant
//   inc_pulse  : registered one-hot increment strobe
//   grant_idx  : index of the last granted digit
//   active     : some requester is not IDLE
module inc_arbiter
  import cnt_pkg::*;
#(
  parameter int DIGITS       = 2,
  parameter int HOLD_TICKS   = 4,
  parameter int REPEAT_TICKS = 2,
  parameter int CNT_W        = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DIGITS-1:0]           req,
  input  logic                        tick,
  output logic [DIGITS-1:0]           inc_pulse,
  output logic [idx_w(DIGITS)-1:0]    grant_idx,
  output logic                        active
);

  localparam int IDX_W = idx_w(DIGITS);

  logic [DIGITS-1:0] w_due;
  logic [DIGITS-1:0] w_grant;
  logic [DIGITS-1:0] w_busy;
  logic [DIGITS-1:0] r_inc_pulse;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_grant_idx;
  logic [IDX_W-1:0]  w_sel;
  logic [IDX_W-1:0]  w_ptr_nxt;
  logic              w_found;
  req_state_t        w_state [DIGITS];

  genvar gd;
  generate
    for (gd = 0; gd < DIGITS; gd++) begin : g_req
      inc_req_timer #(
        .HOLD_TICKS  (HOLD_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS),
        .CNT_W       (CNT_W)
      ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req  (req[gd]),
        .i_tick (tick),
        .i_grant(w_grant[gd]),
        .o_due  (w_due[gd]),
        .o_state(w_state[gd])
      );
      assign w_busy[gd] = (w_state[gd] != IDLE);
    end
  endgenerate

  // Round-robin search: first due requester at or after the pointer.
  always_comb begin
    logic [IDX_W:0] w_j;
    w_found = 1'b0;
    w_sel   = '0;
    w_j     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_j = {1'b0, r_ptr} + (IDX_W+1)'(i);
      if (w_j >= (IDX_W+1)'(DIGITS)) w_j = w_j - (IDX_W+1)'(DIGITS);
      if (!w_found && w_due[w_j[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_j[IDX_W-1:0];
      end
    end
  end

  assign w_ptr_nxt = (w_sel == IDX_W'(DIGITS - 1)) ? '0 : w_sel + IDX_W'(1);
  assign w_grant   = (tick && w_found) ? (DIGITS'(1) << w_sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inc_pulse <= '0;
      r_grant_idx <= '0;
      r_ptr       <= '0;
    end else begin
      r_inc_pulse <= w_grant;
      if (tick && w_found) begin
        r_grant_idx <= w_sel;
        r_ptr       <= w_ptr_nxt;
      end
    end
  end

  assign inc_pulse = r_inc_pulse;
  assign grant_idx = r_grant_idx;
  // OR of flop outputs only, so it changes exactly with the state registers.
  assign active    = |w_busy;

endmodule

// File: tb/tb_inc_arbiter.sv
module tb_inc_arbiter;

  localparam int DIGITS = 2;
  localparam int HOLD_T = 4;
  localparam int REP_T  = 2;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = 1;
  localparam int W      = DIGITS + IDX_W + 1;

  localparam int S_IDLE = 0, S_FIRST = 1, S_HOLD = 2, S_REP = 3, S_DONE = 4;

  logic              clk;
  logic              rst_n;
  logic [DIGITS-1:0] req;
  logic              tick;
  logic [DIGITS-1:0] inc_pulse;
  logic [IDX_W-1:0]  grant_idx;
  logic              active;

  logic [W-1:0] exp_q[$];
  int           log_q[$];
  int           exp_log[$];
  int           vectors;
  int           miscompares;
  int           tick_no;

  int m_st [DIGITS];
  int m_cnt[DIGITS];
  int m_ptr;
  int m_gidx;

  inc_arbiter #(
    .DIGITS      (DIGITS),
    .HOLD_TICKS  (HOLD_T),
    .REPEAT_TICKS(REP_T),
    .CNT_W       (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .tick     (tick),
    .inc_pulse(inc_pulse),
    .grant_idx(grant_idx),
    .active   (active)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < DIGITS; d++) begin
      m_st[d]  = S_IDLE;
      m_cnt[d] = 0;
    end
    m_ptr  = 0;
    m_gidx = 0;
  endtask

  // Reference behaviour for one clock edge with inputs r/t; pushes the
  // outputs expected right after that edge.
  task automatic model_push(input logic [DIGITS-1:0] r, input logic t);
    bit               due [DIGITS];
    logic [DIGITS-1:0] pulse;
    logic             act;
    int               g;
    g     = -1;
    pulse = '0;
    act   = 1'b0;
    for (int d = 0; d < DIGITS; d++)
      due[d] = (m_st[d] == S_FIRST) ||
               (m_st[d] == S_HOLD && m_cnt[d] + 1 >= HOLD_T) ||
               (m_st[d] == S_REP  && m_cnt[d] + 1 >= REP_T);
    if (t) begin
      for (int i = 0; i < DIGITS; i++) begin
        int j;
        j = (m_ptr + i) % DIGITS;
        if (g < 0 && due[j]) g = j;
      end
    end
    if (g >= 0) begin
      pulse[g] = 1'b1;
      m_gidx   = g;
      m_ptr    = (g + 1) % DIGITS;
    end
    for (int d = 0; d < DIGITS; d++) begin
      if (!r[d]) begin
        m_st[d]  = S_IDLE;
        m_cnt[d] = 0;
      end else begin
        case (m_st[d])
          S_IDLE:  m_st[d] = S_FIRST;
          S_FIRST: if (g == d) begin
`ifdef INC_ARB_AUTOREPEAT_EN
            m_st[d] = S_HOLD;
`else
            m_st[d] = S_DONE;
`endif
            m_cnt[d] = 0;
          end
          S_HOLD, S_REP: if (t) begin
            if (g == d) begin
              m_st[d]  = S_REP;
              m_cnt[d] = 0;
            end else if (m_cnt[d] < (1 << CNT_W) - 1) begin
              m_cnt[d] = m_cnt[d] + 1;
            end
          end
          default: ;
        endcase
      end
      if (m_st[d] != S_IDLE) act = 1'b1;
    end
    exp_q.push_back({act, IDX_W'(m_gidx), pulse});
  endtask

  // Driver: compare the previous edge's outputs, then apply new inputs.
  task automatic step(input logic [DIGITS-1:0] r, input logic t);
    logic [W-1:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("inc_pulse", 32'(inc_pulse), 32'(e[DIGITS-1:0]));
      check("grant_idx", 32'(grant_idx), 32'(e[DIGITS+IDX_W-1:DIGITS]));
      check("active", 32'(active), 32'(e[W-1]));
      check("onehot", 32'($countones(inc_pulse) <= 1), 32'd1);
    end
    if (inc_pulse != '0) log_q.push_back(tick_no * 10 + (inc_pulse[1] ? 1 : 0));
    req  = r;
    tick = t;
    if (t) tick_no++;
    model_push(r, t);
  endtask

  task automatic run(input logic [DIGITS-1:0] r, input int n_ticks, input int gap);
    for (int k = 0; k < n_ticks; k++) begin
      step(r, 1'b1);
      repeat (gap) step(r, 1'b0);
    end
  endtask

  task automatic new_scn();
    tick_no = 0;
    log_q.delete();
  endtask

  task automatic check_log(input string tag);
    check({tag, "_count"}, 32'(log_q.size()), 32'(exp_log.size()));
    for (int i = 0; i < log_q.size() && i < exp_log.size(); i++)
      check(tag, 32'(log_q[i]), 32'(exp_log[i]));
  endtask

  // Reset with both buttons held and ticks toggling; outputs must stay 0.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_pulse", 32'(inc_pulse), 32'd0);
      check("rst_gidx", 32'(grant_idx), 32'd0);
      check("rst_active", 32'(active), 32'd0);
      req  = 2'b11;
      tick = i[0];
    end
    @(negedge clk);
    check("rst_pulse", 32'(inc_pulse), 32'd0);
    rst_n = 1'b1;
    req   = '0;
    tick  = 1'b0;
    model_reset();
    model_push(req, tick);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    tick_no     = 0;
    req         = '0;
    tick        = 1'b0;
    rst_n       = 1'b0;
    model_reset();

    // Reset, then first tick grants digit 0.
    do_reset(6);
    new_scn();
    step(2'b11, 1'b0); step(2'b11, 1'b0); step(2'b11, 1'b1);
    repeat (3) step(2'b00, 1'b0);
    exp_log = '{10};
    check_log("post_reset");

    // Single hold on digit 0 over ticks 1..11.
    new_scn();
    repeat (2) step(2'b01, 1'b0);
    run(2'b01, 11, 2);
    repeat (3) step(2'b00, 1'b0);
`ifdef INC_ARB_AUTOREPEAT_EN
    exp_log = '{10, 50, 70, 90, 110};
`else
    exp_log = '{10};
`endif
    check_log("hold");

    // Tap on digit 1 spanning tick 1.
    new_scn();
    step(2'b10, 1'b0); step(2'b10, 1'b1); step(2'b10, 1'b0); step(2'b00, 1'b0);
    run(2'b00, 9, 1);
    exp_log = '{11};
    check_log("tap");

    // Contention, pointer starts at 0.
    new_scn();
    repeat (2) step(2'b11, 1'b0);
    run(2'b11, 8, 1);
    repeat (3) step(2'b00, 1'b0);
`ifdef INC_ARB_AUTOREPEAT_EN
    exp_log = '{10, 21, 50, 61, 70, 81};
`else
    exp_log = '{10, 21};
`endif
    check_log("contend");

    // Rise in the tick cycle is not granted until the next tick.
    new_scn();
    step(2'b00, 1'b0); step(2'b01, 1'b1); step(2'b01, 1'b0); step(2'b01, 1'b1);
    step(2'b01, 1'b0); step(2'b00, 1'b0); step(2'b00, 1'b0);
    exp_log = '{20};
    check_log("edge");

    // Release during the tick cycle: pulse fires, nothing afterwards.
    new_scn();
    step(2'b01, 1'b0); step(2'b00, 1'b1);
    run(2'b00, 4, 1);
    exp_log = '{10};
    check_log("release");

    // Hold 10 ticks, drop one cycle, press again.
    new_scn();
    step(2'b01, 1'b0);
    run(2'b01, 10, 1);
    step(2'b00, 1'b0); step(2'b01, 1'b0);
    step(2'b01, 1'b1); step(2'b01, 1'b0); step(2'b01, 1'b1); step(2'b01, 1'b0);
    repeat (2) step(2'b00, 1'b0);
`ifdef INC_ARB_AUTOREPEAT_EN
    exp_log = '{10, 50, 70, 90, 110};
`else
    exp_log = '{10, 110};
`endif
    check_log("repress");

    // Reset asserted while a pulse is high clears it immediately.
    step(2'b01, 1'b0); step(2'b01, 1'b1);
    @(posedge clk);
    #1;
    check("pulse_before_rst", 32'(inc_pulse), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_clear", 32'(inc_pulse), 32'd0);
    do_reset(3);
    new_scn();
    repeat (4) step(2'b01, 1'b0);
    step(2'b00, 1'b0); step(2'b00, 1'b0);
    exp_log = {};
    check_log("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
